// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, state encoding and FIFO entry type for the fetch stage
package fetch_pkg;
    localparam logic [31:0] NOP_INSN      = 32'h0000_0013;
    localparam logic [6:0]  OPCODE_I_LOAD = 7'b0000011;
    localparam logic [31:0] PC_STEP       = 32'd4;

    typedef enum logic {RUN, LOAD_WB} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two instruction buffer holding {pc, insn} pairs, with flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  entry_t        data_i,
    output entry_t        data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_pop;

    assign empty_o = count_q == '0;
    assign full_o  = count_q == CW'(DEPTH);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;

    // pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push_i);
            rd_ptr_q <= rd_ptr_q + AW'(do_pop);
            count_q  <= count_q + CW'(push_i) - CW'(do_pop);
        end
    end

    // entry storage; a flushed push is discarded
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: in-order instruction fetch with redirect flush and load write-back slot
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        hold,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        insn_valid,
    output logic        delayed_load,
    output logic [4:0]  delayed_rd
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, last_pc_q;
    logic [CW-1:0] outst_q, outst_d, drop_q, drop_d, count;
    logic [4:0]    rd_q, rd_d;
    logic [CW:0]   credit;
    logic          req_fire, push, pop, fifo_empty, fifo_full, is_load;
    entry_t        head, rsp_entry;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .data_i  (rsp_entry),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    // buffered plus in-flight words may never exceed the buffer, so responses always fit
    assign credit         = {1'b0, count} + {1'b0, outst_q};
    assign imem_req_valid = (credit < (CW+1)'(FIFO_DEPTH)) & ~redirect_valid & rst;
    assign imem_req_addr  = fetch_pc_q;
    assign rsp_entry      = '{pc: rsp_pc_q, insn: imem_rsp_data};

    // presentation, consume, drop accounting and next-state selection
    always_comb begin
        req_fire     = imem_req_valid & imem_req_ready;
        insn_valid   = (state_q == RUN) & ~fifo_empty;
        instruction  = insn_valid ? head.insn : NOP_INSN;
        pc           = insn_valid ? head.pc : last_pc_q;
        delayed_load = state_q == LOAD_WB;
        delayed_rd   = rd_q;
        pop          = insn_valid & ~hold;
        is_load      = pop & (head.insn[6:0] == OPCODE_I_LOAD);
        push         = imem_rsp_valid & (drop_q == '0) & ~redirect_valid & (~fifo_full | pop);
        outst_d      = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_d       = redirect_valid ? outst_q - CW'(imem_rsp_valid)
                                      : drop_q - CW'(imem_rsp_valid && drop_q != '0);
        fetch_pc_d   = redirect_valid ? {redirect_pc[31:2], 2'b00}
                                      : req_fire ? fetch_pc_q + PC_STEP : fetch_pc_q;
        rsp_pc_d     = redirect_valid ? {redirect_pc[31:2], 2'b00}
                                      : push ? rsp_pc_q + PC_STEP : rsp_pc_q;
        rd_d         = is_load ? head.insn[11:7] : rd_q;
        state_d      = (is_load && !redirect_valid) ? LOAD_WB : RUN;
    end

    // state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            last_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            last_pc_q  <= pc;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            rd_q       <= rd_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against a one-cycle-latency memory
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        hold;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        insn_valid;
    logic        delayed_load;
    logic [4:0]  delayed_rd;

    logic        mem_stall;
    logic [31:0] mq [$];
    int          checks = 0;
    int          passes = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .hold           (hold),
        .instruction    (instruction),
        .pc             (pc),
        .insn_valid     (insn_valid),
        .delayed_load   (delayed_load),
        .delayed_rd     (delayed_rd)
    );

    always #5 clk = ~clk;

    // memory image: LW x5,0(x0) at 0x200, ADD x6,x5,x5 at 0x204, elsewhere ADDI x1,x0,(addr>>2)
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h200) return 32'h0000_2283;
        if (a == 32'h204) return 32'h0052_8333;
        return {a[13:2], 8'd0, 5'd1, 7'h13};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
        check({tag, "_req_addr"}, imem_req_addr, 32'h100);
        check({tag, "_insn"}, instruction, NOP);
        check({tag, "_pc"}, pc, 32'h100);
        check({tag, "_valid"}, {31'd0, insn_valid}, 32'd0);
        check({tag, "_dload"}, {31'd0, delayed_load}, 32'd0);
        check({tag, "_drd"}, {27'd0, delayed_rd}, 32'd0);
    endtask

    task automatic check_insn(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_insn);
        check({tag, "_valid"}, {31'd0, insn_valid}, 32'd1);
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_insn"}, instruction, exp_insn);
    endtask

    // one clock: record the handshake, return the oldest accepted word the cycle after, land on negedge
    task automatic tick();
        logic        hs;
        logic [31:0] a;
        #1;
        hs = imem_req_valid & imem_req_ready & rst;
        a  = imem_req_addr;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        if (!rst) mq.delete();
        else if (hs) mq.push_back(a);
        if (mq.size() != 0 && !mem_stall && rst) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; hold = 1'b0; mem_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset("reset");
        rst = 1'b1;
        #1;
        check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, 32'h100);
        tick();
        check("c1_valid", {31'd0, insn_valid}, 32'd0);
        check("c1_req_addr", imem_req_addr, 32'h104);
        tick();
        check_insn("c2", 32'h100, 32'h0400_0093);
        for (int k = 3; k <= 6; k++) begin
            tick();
            check_insn("stream", 32'h100 + 32'(4 * (k - 2)), mem_word(32'h100 + 32'(4 * (k - 2))));
        end
        imem_req_ready = 1'b0;
        tick();
        check_insn("stall_drain", 32'h114, mem_word(32'h114));
        tick();
        check("stall_empty_valid", {31'd0, insn_valid}, 32'd0);
        check("stall_empty_insn", instruction, NOP);
        check("stall_empty_pc", pc, 32'h114);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) tick();
            check("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
            check("stall_req_addr", imem_req_addr, 32'h118);
        end
        imem_req_ready = 1'b1;
        tick();
        check("resume_bubble", {31'd0, insn_valid}, 32'd0);
        tick();
        check_insn("resume_a", 32'h118, mem_word(32'h118));
        tick();
        check_insn("resume_b", 32'h11c, mem_word(32'h11c));
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        check("jump_req_addr", imem_req_addr, 32'h200);
        check("jump_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("jump_flushed", {31'd0, insn_valid}, 32'd0);
        tick();
        tick();
        check_insn("lw", 32'h200, 32'h0000_2283);
        tick();
        check("slot_dload", {31'd0, delayed_load}, 32'd1);
        check("slot_drd", {27'd0, delayed_rd}, 32'd5);
        check("slot_insn", instruction, NOP);
        check("slot_valid", {31'd0, insn_valid}, 32'd0);
        tick();
        check_insn("add", 32'h204, 32'h0052_8333);
        check("after_slot_dload", {31'd0, delayed_load}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        check("br_fetch_addr", imem_req_addr, 32'h300);
        tick();
        mem_stall = 1'b1;
        tick();
        check_insn("branch", 32'h300, mem_word(32'h300));
        hold = 1'b1;
        tick();
        check_insn("branch_held", 32'h300, mem_word(32'h300));
        redirect_valid = 1'b1; redirect_pc = 32'h402; hold = 1'b0; mem_stall = 1'b0;
        tick();
        check("redir_req_addr", imem_req_addr, 32'h400);
        check("redir_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("redir_valid0", {31'd0, insn_valid}, 32'd0);
        tick();
        check("drop1_valid", {31'd0, insn_valid}, 32'd0);
        tick();
        check("drop2_valid", {31'd0, insn_valid}, 32'd0);
        tick();
        check_insn("target", 32'h400, 32'h1000_0093);
        hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_req_valid", {31'd0, imem_req_valid}, 32'd0);
            check("hold_req_addr", imem_req_addr, 32'h410);
            check_insn("hold", 32'h400, 32'h1000_0093);
        end
        hold = 1'b0;
        tick();
        check_insn("release_a", 32'h404, mem_word(32'h404));
        tick();
        check_insn("release_b", 32'h408, mem_word(32'h408));
        tick();
        check_insn("release_c", 32'h40c, mem_word(32'h40c));
        #1;
        rst = 1'b0;
        mq.delete();
        imem_rsp_valid = 1'b0;
        #1;
        check_reset("async_rst");
        tick();
        rst = 1'b1;
        #1;
        check("restart_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("restart_req_addr", imem_req_addr, 32'h100);
        tick();
        check("restart_bubble", {31'd0, insn_valid}, 32'd0);
        tick();
        check_insn("restart", 32'h100, 32'h0400_0093);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
